// File: rtl/mldsa_verify_sequencer.sv
// Control sequencer for the ML-DSA Verify_internal datapath: launches each stage in turn,
// watches for reject/timeout, then compares c_tilde against the recomputed c_tilde'.
module mldsa_verify_sequencer #(
  parameter int NUM_STAGES = 10,
  parameter int CTILDE_W   = 512,
  parameter int TIMEOUT    = 65535,
  parameter int TMO_W      = $clog2(TIMEOUT + 1),
  parameter int IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [NUM_STAGES-1:0] stage_rst,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [NUM_STAGES-1:0] stage_ok,
  input  logic [CTILDE_W-1:0]   c_tilde,
  input  logic [CTILDE_W-1:0]   c_tilde_prime,
  output logic                  done,
  output logic                  valid,
  output logic [1:0]            err_code,
  output logic [IDX_W-1:0]      err_stage
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COMPARE,
    S_FINISH
  } state_t;

  localparam logic [1:0]       ERR_OK       = 2'b00;
  localparam logic [1:0]       ERR_REJECT   = 2'b01;
  localparam logic [1:0]       ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0]       ERR_MISMATCH = 2'b11;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             valid_q, valid_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [IDX_W-1:0] err_stage_q, err_stage_d;

  logic cur_done;
  logic cur_ok;
  logic ctilde_eq;
  logic stage_active;
  logic stage_launch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      valid_q     <= 1'b0;
      err_code_q  <= ERR_OK;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      valid_q     <= valid_d;
      err_code_q  <= err_code_d;
      err_stage_q <= err_stage_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    valid_d     = valid_q;
    err_code_d  = err_code_q;
    err_stage_d = err_stage_q;
    cur_done    = stage_done[idx_q];
    cur_ok      = stage_ok[idx_q];
    ctilde_eq   = (c_tilde == c_tilde_prime);

    // abort outranks any done or timeout seen in the same cycle
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d     = S_LAUNCH;
            idx_d       = '0;
            valid_d     = 1'b0;
            err_code_d  = ERR_OK;
            err_stage_d = '0;
          end
        end
        S_LAUNCH: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          timer_d = timer_q + TMO_W'(1);
          if (cur_done) begin
            if (!cur_ok) begin
              state_d     = S_FINISH;
              err_code_d  = ERR_REJECT;
              err_stage_d = idx_q;
            end else if (idx_q == LAST_IDX) begin
              state_d = S_COMPARE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_LAUNCH;
            end
          end else if (timer_q == TMO_LAST) begin
            state_d     = S_FINISH;
            err_code_d  = ERR_TIMEOUT;
            err_stage_d = idx_q;
          end
        end
        S_COMPARE: begin
          valid_d    = ctilde_eq;
          err_code_d = ctilde_eq ? ERR_OK : ERR_MISMATCH;
          state_d    = S_FINISH;
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_FINISH);
    stage_launch = (state_q == S_LAUNCH);
    stage_active = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign stage_start[gi] = stage_launch && (idx_q == IDX_W'(gi));
      assign stage_rst[gi]   = !(stage_active && (idx_q == IDX_W'(gi)));
    end
  endgenerate

  assign valid     = valid_q;
  assign err_code  = err_code_q;
  assign err_stage = err_stage_q;

endmodule

// File: tb/tb_mldsa_verify_sequencer.sv
// Directed bench for mldsa_verify_sequencer: a delay-programmable stage responder plus
// hand-computed cycle/status expectations for each scenario.
module tb_mldsa_verify_sequencer;

  localparam int NS  = 10;
  localparam int CW  = 512;
  localparam int TMO = 16;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          busy;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_rst;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] stage_ok;
  logic [CW-1:0] c_tilde;
  logic [CW-1:0] c_tilde_prime;
  logic          done;
  logic          valid;
  logic [1:0]    err_code;
  logic [IW-1:0] err_stage;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  mldsa_verify_sequencer #(
    .NUM_STAGES(NS),
    .CTILDE_W  (CW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .stage_start  (stage_start),
    .stage_rst    (stage_rst),
    .stage_done   (stage_done),
    .stage_ok     (stage_ok),
    .c_tilde      (c_tilde),
    .c_tilde_prime(c_tilde_prime),
    .done         (done),
    .valid        (valid),
    .err_code     (err_code),
    .err_stage    (err_stage)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stage responder: stage i raises done dly[i] cycles after its start pulse (0 = never).
  int            dly[NS];
  logic [NS-1:0] start_seen = '0;
  int            act = 0;
  int            cnt = 0;

  always @(negedge clk) start_seen = stage_start;

  initial stage_done = '0;
  always @(posedge clk) begin
    #1;
    if (start_seen != '0) begin
      for (int i = 0; i < NS; i++) if (start_seen[i]) act = i;
      cnt = dly[act];
    end
    stage_done = '0;
    if (cnt > 0) begin
      if (cnt == 1) stage_done[act] = 1'b1;
      cnt--;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_normal();
    for (int i = 0; i < NS; i++) dly[i] = 1;
    stage_ok      = '1;
    c_tilde_prime = c_tilde;
  endtask

  // One verify run: start in relative cycle 0; returns the cycle done was seen in
  // (-1 if it never came), the OR of all launch pulses and stage_rst in cycle 10.
  task automatic run_seq(input string name, output int dcyc, output logic [NS-1:0] starts_acc,
                         output logic [NS-1:0] rst_mid);
    int t0;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    dcyc = -1;
    starts_acc = '0;
    rst_mid = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      starts_acc |= stage_start;
      if (cyc - t0 == 10) rst_mid = stage_rst;
      if (done) begin
        dcyc = cyc - t0;
        break;
      end
    end
    $display("[TB] %s: done@%0d valid=%0b err=%0d err_stage=%0d starts=%h",
             name, dcyc, valid, err_code, err_stage, starts_acc);
  endtask

  int            dcyc;
  logic [NS-1:0] sacc;
  logic [NS-1:0] rmid;
  int            dn;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < CW / 32; i++) c_tilde[i*32 +: 32] = $urandom();
    set_normal();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stage_start", 64'(stage_start), 64'd0);
    check("rst_stage_rst", 64'(stage_rst), 64'h3FF);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_err_stage", 64'(err_stage), 64'd0);

    // 1: all stages pass, hashes match
    run_seq("t1_pass", dcyc, sacc, rmid);
    check("t1_done_cyc", 64'(dcyc), 64'd22);
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_err", 64'(err_code), 64'd0);
    check("t1_err_stage", 64'(err_stage), 64'd0);
    check("t1_starts", 64'(sacc), 64'h3FF);
    check("t1_rst_mid", 64'(rmid), 64'h3EF);
    @(negedge clk);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_done_after", 64'(done), 64'd0);
    check("t1_valid_held", 64'(valid), 64'd1);

    // 2: c_tilde' differs in bit 0
    c_tilde_prime = c_tilde ^ {{(CW-1){1'b0}}, 1'b1};
    run_seq("t2_mismatch", dcyc, sacc, rmid);
    check("t2_done_cyc", 64'(dcyc), 64'd22);
    check("t2_valid", 64'(valid), 64'd0);
    check("t2_err", 64'(err_code), 64'd3);

    // 3: stage 1 rejects
    set_normal();
    stage_ok = 10'h3FD;
    run_seq("t3_reject", dcyc, sacc, rmid);
    check("t3_done_cyc", 64'(dcyc), 64'd5);
    check("t3_err", 64'(err_code), 64'd1);
    check("t3_err_stage", 64'(err_stage), 64'd1);
    check("t3_valid", 64'(valid), 64'd0);
    check("t3_starts", 64'(sacc), 64'h003);

    // 4: stage 4 never acks
    set_normal();
    dly[4] = 0;
    run_seq("t4_timeout", dcyc, sacc, rmid);
    check("t4_done_cyc", 64'(dcyc), 64'd26);
    check("t4_err", 64'(err_code), 64'd2);
    check("t4_err_stage", 64'(err_stage), 64'd4);
    check("t4_rst_mid", 64'(rmid), 64'h3EF);
    check("t4_rst_finish", 64'(stage_rst), 64'h3FF);
    check("t4_starts", 64'(sacc), 64'h01F);

    // 5: stage 4 done coincides with the last watchdog cycle
    set_normal();
    dly[4] = 16;
    run_seq("t5_edge", dcyc, sacc, rmid);
    check("t5_done_cyc", 64'(dcyc), 64'd37);
    check("t5_valid", 64'(valid), 64'd1);
    check("t5_err", 64'(err_code), 64'd0);

    // 6: start while busy (cycle 12), abort in stage 6 WAIT (cycle 15)
    set_normal();
    dly[6] = 0;
    dn = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int r = 1; r <= 25; r++) begin
      @(posedge clk); #1;
      start = (r == 12);
      abort = (r == 15);
      @(negedge clk);
      if (done) dn++;
      if (r == 14) check("t6_rst_wait", 64'(stage_rst), 64'h3BF);
      if (r == 16) begin
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_stage_rst", 64'(stage_rst), 64'h3FF);
        check("t6_valid", 64'(valid), 64'd0);
        check("t6_err", 64'(err_code), 64'd0);
      end
    end
    $display("[TB] t6_abort: dones=%0d busy=%0b valid=%0b", dn, busy, valid);
    check("t6_no_done", 64'(dn), 64'd0);
    check("t6_idle", 64'(busy), 64'd0);
    set_normal();
    run_seq("t6_rerun", dcyc, sacc, rmid);
    check("t6_rerun_cyc", 64'(dcyc), 64'd22);
    check("t6_rerun_valid", 64'(valid), 64'd1);

    // 7: asynchronous reset mid-run
    dn = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int r = 1; r <= 30; r++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (r == 7) begin
        #2;
        rst = 1'b1;
        #1;
        check("t7_busy_async", 64'(busy), 64'd0);
        check("t7_rst_async", 64'(stage_rst), 64'h3FF);
      end
      if (r == 8) rst = 1'b0;
      @(negedge clk);
      if (done) dn++;
    end
    $display("[TB] t7_async_rst: dones=%0d busy=%0b", dn, busy);
    check("t7_no_done", 64'(dn), 64'd0);
    check("t7_valid", 64'(valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
